// File: rtl/punc_control_if.sv
// Control/status bundle between the PUnC controller (master) and the LC3 datapath (slave).
// Carries IR and condition codes up; every select, load and write-enable down.
interface punc_control_if;
  logic [15:0] ir;
  logic        n_flag;
  logic        z_flag;
  logic        p_flag;
  logic [15:0] pc_clr_val;
  logic        pc_ld;
  logic        pc_data_sel;
  logic        pc_add_sel;
  logic        pc_inc;
  logic        ir_ld;
  logic [1:0]  mem_addr_sel;
  logic        mem_w_en;
  logic        store_ld;
  logic [2:0]  rf_r_addr_0;
  logic [2:0]  rf_r_addr_1;
  logic [2:0]  rf_w_addr;
  logic        rf_w_en;
  logic [1:0]  rf_w_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        sext_sel;
  logic [1:0]  alu_op;
  logic        nzp_ld;
  logic        nzp_sel;
  logic        halted;
  logic [2:0]  state_debug;

  modport master (
    input  ir, n_flag, z_flag, p_flag,
    output pc_clr_val, pc_ld, pc_data_sel, pc_add_sel, pc_inc, ir_ld,
           mem_addr_sel, mem_w_en, store_ld,
           rf_r_addr_0, rf_r_addr_1, rf_w_addr, rf_w_en, rf_w_sel,
           alu_a_sel, alu_b_sel, sext_sel, alu_op, nzp_ld, nzp_sel,
           halted, state_debug
  );

  modport slave (
    output ir, n_flag, z_flag, p_flag,
    input  pc_clr_val, pc_ld, pc_data_sel, pc_add_sel, pc_inc, ir_ld,
           mem_addr_sel, mem_w_en, store_ld,
           rf_r_addr_0, rf_r_addr_1, rf_w_addr, rf_w_en, rf_w_sel,
           alu_a_sel, alu_b_sel, sext_sel, alu_op, nzp_ld, nzp_sel,
           halted, state_debug
  );
endinterface

// File: rtl/punc_control.sv
// PUnC LC3 control FSM: FETCH/DECODE/EXEC[/EXEC2] per instruction, HALT is sticky until reset.
// Latency: 3 cycles per instruction, 4 for LDI/STI; outputs are combinational from state+IR.
// No backpressure; PUNC_ILLEGAL_HALT_EN makes opcodes 1000/1101 halt instead of acting as NOP.
module punc_control #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  punc_control_if.master       ctl
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] MEM_PC    = 2'd0;
  localparam logic [1:0] MEM_ALU   = 2'd1;
  localparam logic [1:0] MEM_PCADD = 2'd2;
  localparam logic [1:0] MEM_STORE = 2'd3;

  localparam logic [1:0] RFW_PC    = 2'd0;
  localparam logic [1:0] RFW_MEM   = 2'd1;
  localparam logic [1:0] RFW_ALU   = 2'd2;
  localparam logic [1:0] RFW_PCADD = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_PASSA = 2'b10;
  localparam logic [1:0] ALU_NOT   = 2'b11;

  state_t     r_state;
  state_t     w_next;

  logic [3:0] w_op;
  logic [2:0] w_dr;
  logic [2:0] w_base;
  logic       w_br_taken;
  logic       w_unused;

  logic       w_pc_ld;
  logic       w_pc_data_sel;
  logic       w_pc_add_sel;
  logic       w_pc_inc;
  logic       w_ir_ld;
  logic [1:0] w_mem_addr_sel;
  logic       w_mem_w_en;
  logic       w_store_ld;
  logic [2:0] w_rf_r_addr_0;
  logic [2:0] w_rf_r_addr_1;
  logic [2:0] w_rf_w_addr;
  logic       w_rf_w_en;
  logic [1:0] w_rf_w_sel;
  logic       w_alu_a_sel;
  logic       w_alu_b_sel;
  logic       w_sext_sel;
  logic [1:0] w_alu_op;
  logic       w_nzp_ld;
  logic       w_nzp_sel;

  assign w_op       = ctl.ir[15:12];
  assign w_dr       = ctl.ir[11:9];
  assign w_base     = ctl.ir[8:6];
  assign w_br_taken = (ctl.ir[11] & ctl.n_flag) | (ctl.ir[10] & ctl.z_flag) |
                      (ctl.ir[9] & ctl.p_flag);
  assign w_unused   = ^ctl.ir[4:3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_pc_ld        = 1'b0;
    w_pc_data_sel  = 1'b0;
    w_pc_add_sel   = 1'b0;
    w_pc_inc       = 1'b0;
    w_ir_ld        = 1'b0;
    w_mem_addr_sel = MEM_PC;
    w_mem_w_en     = 1'b0;
    w_store_ld     = 1'b0;
    w_rf_r_addr_0  = 3'd0;
    w_rf_r_addr_1  = 3'd0;
    w_rf_w_addr    = 3'd0;
    w_rf_w_en      = 1'b0;
    w_rf_w_sel     = RFW_PC;
    w_alu_a_sel    = 1'b0;
    w_alu_b_sel    = 1'b0;
    w_sext_sel     = 1'b0;
    w_alu_op       = ALU_ADD;
    w_nzp_ld       = 1'b0;
    w_nzp_sel      = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_addr_sel = MEM_PC;
        w_ir_ld        = 1'b1;
        w_pc_inc       = 1'b1;
        w_next         = S_DECODE;
      end

      S_DECODE: begin
        w_next = S_EXEC;
        if (w_op == OP_TRAP) begin
          w_next = S_HALT;
        end
`ifdef PUNC_ILLEGAL_HALT_EN
        if (w_op == 4'b1000 || w_op == 4'b1101) begin
          w_next = S_HALT;
        end
`endif
      end

      S_EXEC: begin
        w_next = S_FETCH;
        case (w_op)
          OP_ADD, OP_AND, OP_NOT: begin
            w_rf_r_addr_0 = w_base;
            w_alu_a_sel   = 1'b1;
            w_alu_op      = (w_op == OP_ADD) ? ALU_ADD :
                            (w_op == OP_AND) ? ALU_AND : ALU_NOT;
            if (ctl.ir[5]) begin
              w_alu_b_sel = 1'b1;
              w_sext_sel  = 1'b0;
            end else begin
              w_alu_b_sel   = 1'b0;
              w_rf_r_addr_1 = ctl.ir[2:0];
            end
            w_rf_w_sel  = RFW_ALU;
            w_rf_w_addr = w_dr;
            w_rf_w_en   = 1'b1;
            w_nzp_sel   = 1'b0;
            w_nzp_ld    = 1'b1;
          end

          OP_BR: begin
            w_pc_add_sel  = 1'b0;
            w_pc_data_sel = 1'b0;
            w_pc_ld       = w_br_taken;
          end

          OP_JMP: begin
            w_rf_r_addr_0 = w_base;
            w_alu_a_sel   = 1'b1;
            w_alu_op      = ALU_PASSA;
            w_pc_data_sel = 1'b1;
            w_pc_ld       = 1'b1;
          end

          // R7 is written on the same edge PC loads, so a JSRR R7 target reads the old R7.
          OP_JSR: begin
            w_rf_w_addr = 3'd7;
            w_rf_w_sel  = RFW_PC;
            w_rf_w_en   = 1'b1;
            w_pc_ld     = 1'b1;
            if (ctl.ir[11]) begin
              w_pc_add_sel  = 1'b1;
              w_pc_data_sel = 1'b0;
            end else begin
              w_rf_r_addr_0 = w_base;
              w_alu_a_sel   = 1'b1;
              w_alu_op      = ALU_PASSA;
              w_pc_data_sel = 1'b1;
            end
          end

          OP_LD: begin
            w_mem_addr_sel = MEM_PCADD;
            w_pc_add_sel   = 1'b0;
            w_rf_w_sel     = RFW_MEM;
            w_rf_w_addr    = w_dr;
            w_rf_w_en      = 1'b1;
            w_nzp_sel      = 1'b1;
            w_nzp_ld       = 1'b1;
          end

          OP_LDR: begin
            w_rf_r_addr_0  = w_base;
            w_alu_a_sel    = 1'b1;
            w_alu_b_sel    = 1'b1;
            w_sext_sel     = 1'b1;
            w_alu_op       = ALU_ADD;
            w_mem_addr_sel = MEM_ALU;
            w_rf_w_sel     = RFW_MEM;
            w_rf_w_addr    = w_dr;
            w_rf_w_en      = 1'b1;
            w_nzp_sel      = 1'b1;
            w_nzp_ld       = 1'b1;
          end

          OP_LEA: begin
            w_pc_add_sel = 1'b0;
            w_rf_w_sel   = RFW_PCADD;
            w_rf_w_addr  = w_dr;
            w_rf_w_en    = 1'b1;
          end

          OP_ST: begin
            w_mem_addr_sel = MEM_PCADD;
            w_pc_add_sel   = 1'b0;
            w_rf_r_addr_1  = w_dr;
            w_mem_w_en     = 1'b1;
          end

          OP_STR: begin
            w_rf_r_addr_0  = w_base;
            w_alu_a_sel    = 1'b1;
            w_alu_b_sel    = 1'b1;
            w_sext_sel     = 1'b1;
            w_alu_op       = ALU_ADD;
            w_mem_addr_sel = MEM_ALU;
            w_rf_r_addr_1  = w_dr;
            w_mem_w_en     = 1'b1;
          end

          // Fetch the pointer into the store reg; the indirect access happens in EXEC2.
          OP_LDI, OP_STI: begin
            w_mem_addr_sel = MEM_PCADD;
            w_pc_add_sel   = 1'b0;
            w_store_ld     = 1'b1;
            w_next         = S_EXEC2;
          end

          default: begin
          end
        endcase
      end

      S_EXEC2: begin
        w_next         = S_FETCH;
        w_mem_addr_sel = MEM_STORE;
        if (w_op == OP_LDI) begin
          w_rf_w_sel  = RFW_MEM;
          w_rf_w_addr = w_dr;
          w_rf_w_en   = 1'b1;
          w_nzp_sel   = 1'b1;
          w_nzp_ld    = 1'b1;
        end else if (w_op == OP_STI) begin
          w_rf_r_addr_1 = w_dr;
          w_mem_w_en    = 1'b1;
        end
      end

      S_HALT: begin
        w_next = S_HALT;
      end

      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Enables are gated by rst so nothing commits while reset is held.
  assign ctl.pc_clr_val   = RESET_PC;
  assign ctl.pc_ld        = w_pc_ld    & rst;
  assign ctl.pc_inc       = w_pc_inc   & rst;
  assign ctl.ir_ld        = w_ir_ld    & rst;
  assign ctl.mem_w_en     = w_mem_w_en & rst;
  assign ctl.store_ld     = w_store_ld & rst;
  assign ctl.rf_w_en      = w_rf_w_en  & rst;
  assign ctl.nzp_ld       = w_nzp_ld   & rst;
  assign ctl.pc_data_sel  = w_pc_data_sel;
  assign ctl.pc_add_sel   = w_pc_add_sel;
  assign ctl.mem_addr_sel = w_mem_addr_sel;
  assign ctl.rf_r_addr_0  = w_rf_r_addr_0;
  assign ctl.rf_r_addr_1  = w_rf_r_addr_1;
  assign ctl.rf_w_addr    = w_rf_w_addr;
  assign ctl.rf_w_sel     = w_rf_w_sel;
  assign ctl.alu_a_sel    = w_alu_a_sel;
  assign ctl.alu_b_sel    = w_alu_b_sel;
  assign ctl.sext_sel     = w_sext_sel;
  assign ctl.alu_op       = w_alu_op;
  assign ctl.nzp_sel      = w_nzp_sel;
  assign ctl.halted       = (r_state == S_HALT) & rst;
  assign ctl.state_debug  = r_state;

endmodule

// File: tb/tb_punc_control.sv
// Scoreboard bench for punc_control: expected per-cycle control words are queued as instructions are driven.
module tb_punc_control;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  punc_control_if bus ();

  punc_control #(.RESET_PC(16'h3000)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_data_sel;
    logic       pc_add_sel;
    logic       pc_inc;
    logic       ir_ld;
    logic [1:0] mem_addr_sel;
    logic       mem_w_en;
    logic       store_ld;
    logic [2:0] rf_r_addr_0;
    logic [2:0] rf_r_addr_1;
    logic [2:0] rf_w_addr;
    logic       rf_w_en;
    logic [1:0] rf_w_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       sext_sel;
    logic [1:0] alu_op;
    logic       nzp_ld;
    logic       nzp_sel;
    logic       halted;
    logic [2:0] state;
  } ctrl_t;

  typedef struct {
    logic        rst;
    logic [2:0]  st;
    logic [15:0] ir;
    logic        n, z, p;
  } sb_t;

  sb_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t sample();
    ctrl_t s;
    s.pc_ld = bus.pc_ld;             s.pc_data_sel = bus.pc_data_sel;
    s.pc_add_sel = bus.pc_add_sel;   s.pc_inc = bus.pc_inc;
    s.ir_ld = bus.ir_ld;             s.mem_addr_sel = bus.mem_addr_sel;
    s.mem_w_en = bus.mem_w_en;       s.store_ld = bus.store_ld;
    s.rf_r_addr_0 = bus.rf_r_addr_0; s.rf_r_addr_1 = bus.rf_r_addr_1;
    s.rf_w_addr = bus.rf_w_addr;     s.rf_w_en = bus.rf_w_en;
    s.rf_w_sel = bus.rf_w_sel;       s.alu_a_sel = bus.alu_a_sel;
    s.alu_b_sel = bus.alu_b_sel;     s.sext_sel = bus.sext_sel;
    s.alu_op = bus.alu_op;           s.nzp_ld = bus.nzp_ld;
    s.nzp_sel = bus.nzp_sel;         s.halted = bus.halted;
    s.state = bus.state_debug;
    return s;
  endfunction

  // Expected control word plus a mask of the fields that matter in this state/opcode.
  function automatic void model(input sb_t s, output ctrl_t e, output ctrl_t m);
    logic [3:0] op;
    op = s.ir[15:12];
    e = '0;
    m = '0;
    m.pc_ld = 1; m.pc_inc = 1; m.ir_ld = 1; m.mem_w_en = 1; m.store_ld = 1;
    m.rf_w_en = 1; m.nzp_ld = 1; m.halted = 1; m.state = '1;
    if (!s.rst) return;
    e.state  = s.st;
    e.halted = (s.st == 3'd4);
    if (s.st == 3'd0) begin
      e.ir_ld = 1; e.pc_inc = 1; m.mem_addr_sel = '1;
    end else if (s.st == 3'd2) begin
      case (op)
        4'h1, 4'h5, 4'h9: begin
          e.rf_r_addr_0 = s.ir[8:6]; m.rf_r_addr_0 = '1;
          e.alu_a_sel = 1; m.alu_a_sel = 1;
          e.alu_op = (op == 4'h1) ? 2'b00 : (op == 4'h5) ? 2'b01 : 2'b11; m.alu_op = '1;
          m.alu_b_sel = 1;
          if (s.ir[5]) begin
            e.alu_b_sel = 1; m.sext_sel = 1;
          end else begin
            e.rf_r_addr_1 = s.ir[2:0]; m.rf_r_addr_1 = '1;
          end
          e.rf_w_sel = 2'd2; m.rf_w_sel = '1;
          e.rf_w_addr = s.ir[11:9]; m.rf_w_addr = '1;
          e.rf_w_en = 1; m.nzp_sel = 1; e.nzp_ld = 1;
        end
        4'h0: begin
          m.pc_add_sel = 1; m.pc_data_sel = 1;
          e.pc_ld = (s.ir[11] & s.n) | (s.ir[10] & s.z) | (s.ir[9] & s.p);
        end
        4'hC: begin
          e.rf_r_addr_0 = s.ir[8:6]; m.rf_r_addr_0 = '1;
          e.alu_a_sel = 1; m.alu_a_sel = 1; e.alu_op = 2'b10; m.alu_op = '1;
          e.pc_data_sel = 1; m.pc_data_sel = 1; e.pc_ld = 1;
        end
        4'h4: begin
          e.rf_w_addr = 3'd7; m.rf_w_addr = '1; m.rf_w_sel = '1;
          e.rf_w_en = 1; e.pc_ld = 1; m.pc_data_sel = 1;
          if (s.ir[11]) begin
            e.pc_add_sel = 1; m.pc_add_sel = 1;
          end else begin
            e.rf_r_addr_0 = s.ir[8:6]; m.rf_r_addr_0 = '1;
            e.alu_a_sel = 1; m.alu_a_sel = 1; e.alu_op = 2'b10; m.alu_op = '1;
            e.pc_data_sel = 1;
          end
        end
        4'h2, 4'h6: begin
          if (op == 4'h2) begin
            e.mem_addr_sel = 2'd2; m.pc_add_sel = 1;
          end else begin
            e.mem_addr_sel = 2'd1;
            e.rf_r_addr_0 = s.ir[8:6]; m.rf_r_addr_0 = '1;
            e.alu_a_sel = 1; m.alu_a_sel = 1; e.alu_b_sel = 1; m.alu_b_sel = 1;
            e.sext_sel = 1; m.sext_sel = 1; m.alu_op = '1;
          end
          m.mem_addr_sel = '1;
          e.rf_w_sel = 2'd1; m.rf_w_sel = '1;
          e.rf_w_addr = s.ir[11:9]; m.rf_w_addr = '1;
          e.rf_w_en = 1; e.nzp_sel = 1; m.nzp_sel = 1; e.nzp_ld = 1;
        end
        4'hE: begin
          m.pc_add_sel = 1; e.rf_w_sel = 2'd3; m.rf_w_sel = '1;
          e.rf_w_addr = s.ir[11:9]; m.rf_w_addr = '1; e.rf_w_en = 1;
        end
        4'h3, 4'h7: begin
          if (op == 4'h3) begin
            e.mem_addr_sel = 2'd2; m.pc_add_sel = 1;
          end else begin
            e.mem_addr_sel = 2'd1;
            e.rf_r_addr_0 = s.ir[8:6]; m.rf_r_addr_0 = '1;
            e.alu_a_sel = 1; m.alu_a_sel = 1; e.alu_b_sel = 1; m.alu_b_sel = 1;
            e.sext_sel = 1; m.sext_sel = 1; m.alu_op = '1;
          end
          m.mem_addr_sel = '1;
          e.rf_r_addr_1 = s.ir[11:9]; m.rf_r_addr_1 = '1; e.mem_w_en = 1;
        end
        4'hA, 4'hB: begin
          e.mem_addr_sel = 2'd2; m.mem_addr_sel = '1; m.pc_add_sel = 1; e.store_ld = 1;
        end
        default: begin
        end
      endcase
    end else if (s.st == 3'd3) begin
      e.mem_addr_sel = 2'd3; m.mem_addr_sel = '1;
      if (op == 4'hA) begin
        e.rf_w_sel = 2'd1; m.rf_w_sel = '1;
        e.rf_w_addr = s.ir[11:9]; m.rf_w_addr = '1;
        e.rf_w_en = 1; e.nzp_sel = 1; m.nzp_sel = 1; e.nzp_ld = 1;
      end else begin
        e.rf_r_addr_1 = s.ir[11:9]; m.rf_r_addr_1 = '1; e.mem_w_en = 1;
      end
    end
  endfunction

  task automatic compare_entry(input sb_t s);
    ctrl_t e, m, g;
    model(s, e, m);
    g = sample();
    chk($sformatf("ir=%h st=%0d rst=%0b", s.ir, s.st, s.rst), 32'(g & m), 32'(e & m));
  endtask

  task automatic pop_and_compare();
    sb_t s;
    if (sb_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      s = sb_q.pop_front();
      compare_entry(s);
    end
  endtask

  // Called just after the edge into FETCH; stops after 'cut' cycles if cut>0.
  task automatic run(input logic [15:0] instr, input logic [2:0] nzp, input int halt_cycles,
                     input int cut);
    sb_t s;
    logic [3:0] op;
    logic to_halt;
    int done;
    op = instr[15:12];
    bus.ir = instr;
    {bus.n_flag, bus.z_flag, bus.p_flag} = nzp;
    s.rst = 1'b1; s.ir = instr; {s.n, s.z, s.p} = nzp;
    to_halt = (op == 4'hF);
`ifdef PUNC_ILLEGAL_HALT_EN
    if (op == 4'h8 || op == 4'hD) to_halt = 1'b1;
`endif
    s.st = 3'd0; sb_q.push_back(s);
    s.st = 3'd1; sb_q.push_back(s);
    if (to_halt) begin
      for (int i = 0; i < halt_cycles; i++) begin
        s.st = 3'd4; sb_q.push_back(s);
      end
    end else begin
      s.st = 3'd2; sb_q.push_back(s);
      if (op == 4'hA || op == 4'hB) begin
        s.st = 3'd3; sb_q.push_back(s);
      end
    end
    done = 0;
    while (sb_q.size() > 0 && (cut == 0 || done < cut)) begin
      @(negedge clk);
      pop_and_compare();
      done++;
      @(posedge clk);
      #1;
    end
    sb_q.delete();
  endtask

  task automatic reset_check();
    sb_t s;
    s.rst = 1'b0; s.st = 3'd0; s.ir = bus.ir; s.n = 1'b0; s.z = 1'b0; s.p = 1'b0;
    sb_q.push_back(s);
    pop_and_compare();
  endtask

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
  } stim_t;

  stim_t prog[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.ir = 16'h0000;
    bus.n_flag = 1'b0; bus.z_flag = 1'b0; bus.p_flag = 1'b0;

    repeat (2) begin
      @(negedge clk);
      reset_check();
    end
    chk("pc_clr_val", 32'(bus.pc_clr_val), 32'h3000);
    @(posedge clk);
    #1 rst = 1'b1;

    prog = '{
      '{16'h1263, 3'b010}, '{16'h1242, 3'b001}, '{16'h5263, 3'b100}, '{16'h927F, 3'b001},
      '{16'h0A05, 3'b010}, '{16'h0405, 3'b010}, '{16'h0805, 3'b100}, '{16'h0005, 3'b111},
      '{16'h0E05, 3'b001}, '{16'hC1C0, 3'b000}, '{16'h4805, 3'b000}, '{16'h41C0, 3'b000},
      '{16'h2403, 3'b000}, '{16'h6443, 3'b000}, '{16'hE403, 3'b000}, '{16'h3403, 3'b000},
      '{16'h7443, 3'b000}, '{16'hA403, 3'b000}, '{16'hB403, 3'b000}, '{16'h8000, 3'b000},
      '{16'hD000, 3'b000}
    };
    foreach (prog[i]) run(prog[i].ir, prog[i].nzp, 20, 0);

    for (int i = 0; i < 6; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (r[15:12] == 4'hF || r[15:12] == 4'h8 || r[15:12] == 4'hD) r[15:12] = 4'h1;
      run(r, 3'($urandom_range(0, 7)), 20, 0);
    end

    run(16'hF025, 3'b000, 20, 0);
    rst = 1'b0;
    #1 reset_check();
    @(negedge clk);
    reset_check();
    @(posedge clk);
    #1 rst = 1'b1;

    // Reset dropped mid-EXEC2 of STI: write enable must fall without waiting for a clock.
    run(16'hB403, 3'b000, 20, 3);
    begin
      sb_t s;
      s.rst = 1'b1; s.st = 3'd3; s.ir = 16'hB403; s.n = 1'b0; s.z = 1'b0; s.p = 1'b0;
      sb_q.push_back(s);
      #1 pop_and_compare();
    end
    rst = 1'b0;
    #1 reset_check();
    @(posedge clk);
    #1 rst = 1'b1;
    run(16'h1263, 3'b000, 20, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- Control FSM for the PUnC LC3 datapath.
- Sequences fetch, decode and execute for every LC3 instruction the datapath supports.
- Drives every datapath select, load and write-enable line; reads back only the IR and the N/Z/P flags.
- Sits beside the datapath inside the PUnC top level; memory reads are combinational, memory/RF writes land on the clock edge.

Parameters:
- RESET_PC, 16'h0000, value presented on pc_clr_val; PC loads it while rst is low.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- ir  input  16  current instruction register contents
- n_flag, z_flag, p_flag  input  1 each  condition codes from datapath
- pc_clr_val  output  16  constant RESET_PC
- pc_ld  output  1  load PC from pc_data_sel source
- pc_data_sel  output  1  0=PC adder, 1=ALU result
- pc_add_sel  output  1  0=PC+sext(off9), 1=PC+sext(off11)
- pc_inc  output  1  PC<=PC+1
- ir_ld  output  1  IR<=mem read data
- mem_addr_sel  output  2  0=PC, 1=ALU result, 2=PC adder, 3=store reg
- mem_w_en  output  1  memory write, data=rf r_data_1
- store_ld  output  1  store reg<=mem read data
- rf_r_addr_0, rf_r_addr_1, rf_w_addr  output  3 each  RF addresses
- rf_w_en  output  1  RF write
- rf_w_sel  output  2  0=PC, 1=mem data, 2=ALU, 3=PC adder
- alu_a_sel  output  1  0=PC, 1=rf r_data_0
- alu_b_sel  output  1  0=rf r_data_1, 1=sext
- sext_sel  output  1  0=imm5, 1=off6
- alu_op  output  2  00 ADD, 01 AND, 10 PASS_A, 11 NOT
- nzp_ld  output  1  load N/Z/P
- nzp_sel  output  1  0=ALU result, 1=mem data
- halted  output  1  sticky halt indicator
- state_debug  output  3  current state encoding

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, EXEC2=3, HALT=4.
- rst low:
  - state<=FETCH immediately, halted=0.
  - All enables/loads (pc_ld, pc_inc, ir_ld, mem_w_en, rf_w_en, store_ld, nzp_ld) forced 0 while rst is low.
  - Datapath PC takes RESET_PC.
- FETCH: mem_addr_sel=0, ir_ld=1, pc_inc=1; next DECODE.
- DECODE: no enables; next EXEC; opcode 1111 (TRAP/HALT) next HALT.
- EXEC, by ir[15:12]. Outputs are combinational from state+ir, and all effects commit at the EXEC->FETCH edge.
  - ADD(0001)/AND(0101): rf_r_addr_0=ir[8:6], alu_a_sel=1.
    - ir[5]=1: alu_b_sel=1, sext_sel=0.
    - ir[5]=0: alu_b_sel=0, rf_r_addr_1=ir[2:0].
    - rf_w_sel=2, rf_w_addr=ir[11:9], rf_w_en=1, nzp_sel=0, nzp_ld=1.
  - NOT(1001): as ADD, alu_op=11.
  - BR(0000): pc_add_sel=0, pc_data_sel=0; pc_ld=(ir[11]&n)|(ir[10]&z)|(ir[9]&p). nzp=000 never taken.
  - JMP/RET(1100): rf_r_addr_0=ir[8:6], alu_a_sel=1, alu_op=10, pc_data_sel=1, pc_ld=1.
  - JSR/JSRR(0100): rf_w_addr=7, rf_w_sel=0, rf_w_en=1, pc_ld=1.
    - ir[11]=1: pc_add_sel=1, pc_data_sel=0.
    - ir[11]=0: base ir[8:6] through PASS_A, pc_data_sel=1.
    - Base=R7 uses the pre-write R7.
  - LD(0010): mem_addr_sel=2, pc_add_sel=0, rf_w_sel=1, rf_w_en, nzp_sel=1, nzp_ld.
  - LDR(0110): ALU ADD base ir[8:6]+sext off6, mem_addr_sel=1, then as LD.
  - LEA(1110): rf_w_sel=3, rf_w_en; no nzp_ld.
  - ST(0011): mem_addr_sel=2, rf_r_addr_1=ir[11:9], mem_w_en=1.
  - STR(0111): address as LDR, data as ST.
  - LDI(1010)/STI(1011): mem_addr_sel=2, store_ld=1; next EXEC2.
  - Other opcodes: no enables.
  - Next state FETCH except LDI/STI.
- EXEC2: mem_addr_sel=3. LDI does the LD writeback; STI does the ST write. Next FETCH.
- HALT: halted=1, all enables 0, remains until rst low.
- PC adder always uses the already-incremented PC.

Optional Feature:
- Macro PUNC_ILLEGAL_HALT_EN.
- Defined: opcodes 1000 and 1101 go DECODE->HALT, and halted asserts.
- Undefined: these opcodes execute as NOP (EXEC with no enables, then FETCH).

Test Plan:
- R1=5, instr 0x1263 (ADD R1,R1,#3) -> EXEC: rf_w_en=1, rf_w_addr=1, alu_b_sel=1, nzp_ld=1; 3 cycles total, then FETCH.
- z=1, instr 0x0A05 (BRnp) -> pc_ld=0; instr 0x0405 (BRz) -> pc_ld=1, pc_add_sel=0.
- Instr 0xA403 (LDI R2) -> EXEC store_ld=1, mem_addr_sel=2; EXEC2 mem_addr_sel=3, rf_w_en=1, rf_w_addr=2; 4 cycles.
- Instr 0x41C0 (JSRR R7) -> rf_w_addr=7, rf_w_sel=0, pc_data_sel=1, pc_ld=1 in the same cycle.
- Instr 0xF025 -> state 4, halted=1 held 20 cycles, no enables; rst low -> FETCH, halted=0.
- rst pulsed low during EXEC2 of STI -> mem_w_en drops immediately; after release, FETCH with ir_ld=1.
